// File: rtl/score_ram_reader_pkg.sv
// score_ram_reader_pkg
// Shared definitions for the score RAM burst reader:
//   SCORE_W          - width of one score word held in Scores_RAM
//   state_t          - burst-control FSM state encoding
//   score_addr_width - address width needed to reach words 0..n
package score_ram_reader_pkg;

  localparam int SCORE_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // The RAM holds n+1 words (indices 0..n).
  function automatic int score_addr_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/score_skid_fifo.sv
// score_skid_fifo
// Two-entry skid buffer between the RAM read port and the score stream.
// When the buffer is empty, arriving data is presented at the head in the
// same cycle, so an unstalled stream sees no extra latency. Data not taken
// that cycle is stored and re-presented unchanged until accepted.
// Ports:
//   clk, rst          - clock, synchronous active-low reset
//   push_valid/data   - word returning from the RAM this cycle
//   head_valid/data   - oldest word not yet accepted
//   head_ready        - consumer accepts the head word this cycle
//   count             - number of stored words (0..2)
module score_skid_fifo
  import score_ram_reader_pkg::*;
#(
  parameter int W = SCORE_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  input  logic         head_ready,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         stored_s;
  logic         wr_en_s;
  logic         rd_en_s;

  // Head selection: stored words take priority over the word arriving now.
  always_comb begin
    stored_s   = (count_r != 2'd0);
    head_valid = stored_s | push_valid;
    if (stored_s) begin
      head_data = mem_r[rd_ptr_r];
    end else if (push_valid) begin
      head_data = push_data;
    end else begin
      head_data = '0;
    end
    rd_en_s = stored_s & head_ready;
    // An arriving word is stored unless it bypasses straight to the consumer;
    // a full buffer only accepts it when a slot frees in the same cycle.
    if (push_valid && (stored_s || !head_ready) && ((count_r != 2'd2) || rd_en_s)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (rd_en_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, wr_en_s} - {1'b0, rd_en_s};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/score_ram_reader.sv
// score_ram_reader
// Reads a burst of len words from Scores_RAM starting at base_addr
// (wrapping from N back to 0) and streams them out with valid/ready
// handshaking. At most two words are ever outstanding (buffered plus in
// flight), so the two-entry skid buffer can never overflow, while an
// always-ready consumer still receives one word per cycle.
// Ports:
//   clk, rst                  - clock, synchronous active-low reset
//   start, base_addr, len     - burst request, sampled only when idle
//   en_dout, addr_dout        - RAM read enable / address
//   dout                      - RAM data, valid the cycle after a read
//   score_out/valid/ready     - output stream handshake
//   score_last                - marks the final word of the burst
//   busy, done                - burst in progress / completion pulse
module score_ram_reader
  import score_ram_reader_pkg::*;
#(
  parameter int N       = 128,
  parameter int BitAddr = score_addr_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BitAddr:0]   base_addr,
  input  logic [BitAddr:0]   len,
  output logic               en_dout,
  output logic [BitAddr:0]   addr_dout,
  input  logic [SCORE_W-1:0] dout,
  output logic [SCORE_W-1:0] score_out,
  output logic               score_valid,
  input  logic               score_ready,
  output logic               score_last,
  output logic               busy,
  output logic               done
);

  localparam int AW = BitAddr + 1;
  localparam logic [BitAddr:0] LAST_ADDR = AW'(N);
  localparam logic [BitAddr:0] MAX_LEN   = AW'(N + 1);

  state_t             state_r;
  logic [BitAddr:0]   addr_r;
  logic [BitAddr:0]   rem_r;
  logic               rvalid_r;
  logic               rlast_r;
  logic               busy_r;
  logic               done_r;
  logic               issue_s;
  logic               pop_s;
  logic [2:0]         credit_s;
  logic [1:0]         fifo_count_s;
  logic [BitAddr:0]   len_clamped_s;
  logic [SCORE_W:0]   head_s;

  // Burst length limited to the RAM size.
  always_comb begin
    if (len > MAX_LEN) begin
      len_clamped_s = MAX_LEN;
    end else begin
      len_clamped_s = len;
    end
  end

  // Read issue: words still held after this cycle's transfer plus the read
  // in flight must leave room for the read issued now.
  always_comb begin
    credit_s = {1'b0, fifo_count_s} + {2'b00, rvalid_r} - {2'b00, pop_s};
    if ((state_r == ST_READ) && (rem_r != '0) && (credit_s < 3'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Burst-control FSM, read pipeline tracking and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      addr_r   <= '0;
      rem_r    <= '0;
      rvalid_r <= 1'b0;
      rlast_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      // dout carries valid data exactly one cycle after an issued read.
      rvalid_r <= issue_s;
      rlast_r  <= issue_s && (rem_r == AW'(1));
      if (issue_s) begin
        addr_r <= (addr_r == LAST_ADDR) ? '0 : addr_r + AW'(1);
        rem_r  <= rem_r - AW'(1);
      end
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            addr_r <= base_addr;
            rem_r  <= len_clamped_s;
            busy_r <= 1'b1;
            if (len_clamped_s == '0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_READ;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (issue_s && (rem_r == AW'(1))) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_READ;
          end
        end
        ST_DRAIN: begin
          if (pop_s && score_last) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  score_skid_fifo #(
    .W (SCORE_W + 1)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (rvalid_r),
    .push_data  ({rlast_r, dout}),
    .head_valid (score_valid),
    .head_data  (head_s),
    .head_ready (score_ready),
    .count      (fifo_count_s)
  );

  assign pop_s      = score_valid & score_ready;
  assign score_out  = head_s[SCORE_W-1:0];
  assign score_last = score_valid & head_s[SCORE_W];
  assign en_dout    = issue_s;
  assign addr_dout  = addr_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_score_ram_reader.sv
// tb_score_ram_reader
// Directed bench for score_ram_reader (N=128). RAM word k holds 3*k.
// A cycle-by-cycle vector table covers reset and a basic burst; burst
// sequences cover wrap, stalls, len=0, clamping, restart-while-busy and
// mid-burst reset.
module tb_score_ram_reader;

  localparam int N = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] base_addr;
  logic [8:0] len;
  logic       en_dout;
  logic [8:0] addr_dout;
  logic [8:0] dout;
  logic [8:0] score_out;
  logic       score_valid;
  logic       score_ready;
  logic       score_last;
  logic       busy;
  logic       done;

  logic [8:0] ram [0:N];

  int total = 0;
  int bad   = 0;

  int addr_q [$];
  int word_q [$];
  int last_q [$];
  int done_cnt;
  int done_idx;
  int first_valid_idx;

  typedef struct {
    logic       r;
    logic       s;
    logic [8:0] b;
    logic [8:0] l;
    logic       rd;
    bit         chk;
    logic       en;
    logic [8:0] a;
    logic       sv;
    logic [8:0] so;
    logic       sl;
    logic       bz;
    logic       dn;
  } vec_t;

  vec_t vecs [12];

  score_ram_reader #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .len         (len),
    .en_dout     (en_dout),
    .addr_dout   (addr_dout),
    .dout        (dout),
    .score_out   (score_out),
    .score_valid (score_valid),
    .score_ready (score_ready),
    .score_last  (score_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model.
  always @(posedge clk) begin
    if (en_dout) dout <= ram[addr_dout];
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic s, input logic [8:0] b,
                       input logic [8:0] l, input logic rd);
    @(negedge clk);
    rst = r; start = s; base_addr = b; len = l; score_ready = rd;
    #1;
  endtask

  task automatic run_burst(input int b, input int l, input bit stall, input bit extra);
    logic [3:0] pat;
    logic       rdy;
    bit         stalled;
    bit         fin;
    int         held_w;
    int         held_l;
    pat = 4'b1001;
    addr_q.delete(); word_q.delete(); last_q.delete();
    done_cnt = 0; done_idx = -1; first_valid_idx = -1;
    stalled = 1'b0; fin = 1'b0; held_w = 0; held_l = 0;
    for (int idx = 0; idx < 300 && !fin; idx++) begin
      rdy = stall ? pat[idx % 4] : 1'b1;
      if (idx == 0) drive(1'b1, 1'b1, 9'(b), 9'(l), rdy);
      else drive(1'b1, extra && (idx >= 2), 9'd50, 9'd7, rdy);
      if (stalled) begin
        check("hold_valid", int'(score_valid), 1);
        check("hold_data", int'(score_out), held_w);
        check("hold_last", int'(score_last), held_l);
      end
      if (en_dout) addr_q.push_back(int'(addr_dout));
      if (score_valid && first_valid_idx < 0) first_valid_idx = idx;
      if (score_valid && rdy) begin
        word_q.push_back(int'(score_out));
        last_q.push_back(int'(score_last));
      end
      stalled = score_valid && !rdy;
      held_w  = int'(score_out);
      held_l  = int'(score_last);
      if (done) begin
        done_cnt++;
        done_idx = idx;
        fin = 1'b1;
      end
    end
    if (!fin) check("burst_timeout", 0, 1);
  endtask

  task automatic verify(input string tag, input int b, input int l);
    int n;
    int ea;
    n = (l > N + 1) ? N + 1 : l;
    check({tag, "_naddr"}, addr_q.size(), n);
    check({tag, "_nword"}, word_q.size(), n);
    check({tag, "_ndone"}, done_cnt, 1);
    for (int i = 0; i < n && i < addr_q.size() && i < word_q.size(); i++) begin
      ea = (b + i) % (N + 1);
      check($sformatf("%s_addr%0d", tag, i), addr_q[i], ea);
      check($sformatf("%s_word%0d", tag, i), word_q[i], (ea * 3) % 512);
      check($sformatf("%s_last%0d", tag, i), last_q[i], (i == n - 1) ? 1 : 0);
    end
  endtask

  initial begin
    logic [22:0] act;
    logic [22:0] exp;
    bit          bad_seen;

    for (int i = 0; i <= N; i++) ram[i] = 9'(i * 3);
    rst = 1'b0; start = 1'b0; base_addr = 9'd0; len = 9'd0; score_ready = 1'b1;

    //           r     s     b      l      rd    chk   en    a      sv    so      sl    bz    dn
    vecs[0]  = '{1'b0, 1'b0, 9'd0, 9'd0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 9'd0,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 9'd0, 1'b0, 9'd0,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 9'd0, 1'b0, 9'd0,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 9'd0, 9'd5, 1'b1, 1'b1, 1'b0, 9'd0, 1'b0, 9'd0,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 9'd0, 9'd5, 1'b1, 1'b1, 1'b1, 9'd0, 1'b0, 9'd0,  1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 9'd0, 9'd5, 1'b1, 1'b1, 1'b1, 9'd1, 1'b1, 9'd0,  1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 9'd0, 9'd5, 1'b1, 1'b1, 1'b1, 9'd2, 1'b1, 9'd3,  1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 9'd0, 9'd5, 1'b1, 1'b1, 1'b1, 9'd3, 1'b1, 9'd6,  1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 9'd0, 9'd5, 1'b1, 1'b1, 1'b1, 9'd4, 1'b1, 9'd9,  1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 9'd0, 9'd5, 1'b1, 1'b1, 1'b0, 9'd5, 1'b1, 9'd12, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 9'd0, 9'd5, 1'b1, 1'b1, 1'b0, 9'd5, 1'b0, 9'd0,  1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 9'd0, 9'd5, 1'b1, 1'b1, 1'b0, 9'd5, 1'b0, 9'd0,  1'b0, 1'b0, 1'b0};

    // Reset and basic burst: base 0, len 5, always ready.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].l, vecs[i].rd);
      if (vecs[i].chk) begin
        act = {en_dout, addr_dout, score_valid, score_out, score_last, busy, done};
        exp = {vecs[i].en, vecs[i].a, vecs[i].sv, vecs[i].so, vecs[i].sl, vecs[i].bz, vecs[i].dn};
        check($sformatf("vec%0d", i), int'(act), int'(exp));
      end
    end

    // Address wrap 126,127,128,0 and latency with ready held high.
    run_burst(126, 4, 1'b0, 1'b0);
    verify("wrap", 126, 4);
    check("wrap_first_valid", first_valid_idx, 2);
    check("wrap_done_idx", done_idx, 6);

    // Consumer stalls with ready pattern 1,0,0,1,...
    run_burst(40, 6, 1'b1, 1'b0);
    verify("stall", 40, 6);

    // Zero length: done next cycle, no reads, no words.
    run_burst(7, 0, 1'b0, 1'b0);
    verify("len0", 7, 0);
    check("len0_done_idx", done_idx, 1);
    check("len0_no_valid", first_valid_idx, -1);

    // Oversized length clamps to N+1 words.
    run_burst(5, 200, 1'b0, 1'b0);
    verify("clamp", 5, 200);

    // start held while busy (through the done cycle) is ignored.
    run_burst(20, 4, 1'b0, 1'b1);
    verify("restart", 20, 4);
    drive(1'b1, 1'b0, 9'd0, 9'd0, 1'b1);
    check("restart_idle_busy", int'(busy), 0);
    check("restart_idle_en", int'(en_dout), 0);

    // Reset during the 3rd word of a len=10 burst.
    drive(1'b1, 1'b1, 9'd0, 9'd10, 1'b1);
    for (int i = 1; i < 4; i++) drive(1'b1, 1'b0, 9'd0, 9'd10, 1'b1);
    drive(1'b0, 1'b0, 9'd0, 9'd10, 1'b1);
    check("rst_third_word", int'(score_out), 6);
    drive(1'b1, 1'b0, 9'd0, 9'd10, 1'b1);
    act = {en_dout, addr_dout, score_valid, score_out, score_last, busy, done};
    check("rst_outputs_zero", int'(act), 0);
    bad_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 9'd0, 9'd10, 1'b1);
      if (done || score_valid || busy || en_dout) bad_seen = 1'b1;
    end
    check("rst_quiet_after", int'(bad_seen), 0);
    run_burst(10, 3, 1'b0, 1'b0);
    verify("post_rst", 10, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_ram_reader.md
SCORE_RAM_READER -- requirements
Module: score_ram_reader

Interface
REQ-001 Parameter N, default 128, sequence length; the score RAM holds N+1 words.
REQ-002 Parameter BitAddr, default $clog2(N+1); address ports are BitAddr+1 bits wide.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 base_addr  input  BitAddr+1  first RAM address of the burst; captured when start is accepted.
REQ-007 len  input  BitAddr+1  number of words to read; captured when start is accepted.
REQ-008 en_dout  output  1  read enable to Scores_RAM.
REQ-009 addr_dout  output  BitAddr+1  read address to Scores_RAM.
REQ-010 dout  input  9  RAM read data, valid on the cycle after the edge that sampled en_dout=1.
REQ-011 score_out  output  9  streamed score word.
REQ-012 score_valid  output  1  score_out holds a valid word.
REQ-013 score_ready  input  1  consumer accepts the word.
REQ-014 score_last  output  1  qualifies the final word of the burst; asserted together with score_valid.
REQ-015 busy  output  1  high from start acceptance until the done cycle inclusive.
REQ-016 done  output  1  one-cycle pulse after the last word is transferred.

Function
REQ-017 FSM states are IDLE, READ, DRAIN and DONE.
REQ-018 IDLE -> READ on start=1 with len!=0; IDLE -> DONE on start=1 with len=0, so done pulses the next cycle and no word is streamed.
REQ-019 len greater than N+1 is clamped to N+1 at capture.
REQ-020 READ issues one read per cycle (en_dout=1) whenever buffered words plus in-flight reads is less than 2.
REQ-021 The read address starts at base_addr and increments after each issued read; it wraps from N to 0.
REQ-022 READ -> DRAIN when len reads have been issued; DRAIN -> DONE when the last word completes a handshake (score_valid and score_ready both high); DONE -> IDLE unconditionally.
REQ-023 Returning RAM data enters a 2-entry FIFO skid buffer; score_out and score_valid come from the FIFO head.
REQ-024 A transfer occurs on a cycle with score_valid and score_ready both high; the head then pops in that same cycle.
REQ-025 While score_valid=1 and score_ready=0, score_out, score_valid and score_last are held stable; no word is dropped or duplicated.
REQ-026 Latency: with score_ready held at 1, the first score_valid appears 2 cycles after the start cycle, with one word per cycle thereafter.
REQ-027 start is ignored while busy=1.
REQ-028 The word counter and the FIFO count are BitAddr+1 bits and 2 bits respectively; neither may overflow.
REQ-029 en_dout=0 in IDLE, DRAIN and DONE; addr_dout holds its last value when en_dout=0.

Reset
REQ-030 rst=0 at a clock edge forces IDLE, clears the FIFO and counters, and drives en_dout, score_valid, score_last, busy and done to 0, and addr_dout and score_out to 0.
REQ-031 Reset asserted mid-burst aborts the burst; read data arriving after reset is discarded and done is not pulsed.

Structure
REQ-032 A shared package holds the score width (9), the FSM state enumeration and the address-width function of N.
REQ-033 The 2-entry skid buffer is a separate sub-module, score_skid_fifo.

Verification
REQ-034 base_addr=0, len=5, score_ready=1, RAM preloaded with addr*3 -> score_out 0,3,6,9,12 on consecutive cycles, score_last with 12, done 1 cycle later.
REQ-035 base_addr=126, len=4, N=128 -> addresses 126,127,128,0 issued in order.
REQ-036 len=6 with score_ready toggling 1,0,0,1,… -> all 6 words delivered in order, no duplicates, data held stable while stalled.
REQ-037 start with len=0 -> done pulses 1 cycle later, score_valid never asserts, en_dout stays 0.
REQ-038 rst=0 during the 3rd word of a len=10 burst -> all outputs 0 on the next cycle, no done, a new start accepted afterwards.
REQ-039 start pulsed again while busy -> ignored; word count and addresses are those of the first burst only.
